// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer
//   Command-side master for one SuperStack operand stack. Accepts
//   WebAssembly-style stack commands over a valid/ready handshake, drives the
//   stack's op/data port as a short multi-cycle sequence, and reports
//   completion (done pulse) with an error code per command.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   cmd_valid   command request
//   cmd_ready   high only while idle; transfer on cmd_valid && cmd_ready
//   cmd         0=NOP 1=PUSH 2=DROP 3=DUP 4=EQZ 5=ADD 6=SUB 7=AND
//   imm         PUSH immediate, sampled at transfer
//   stk_op      stack op (NONE/PUSH/POP/REPLACE), registered
//   stk_data    stack write data, registered
//   stk_tos     stack top-of-stack
//   stk_status  stack status (NONE/EMPTY/FULL/OVERFLOW/UNDERFLOW)
//   done        one-cycle completion pulse
//   err         0=ok 1=underflow 2=overflow; valid with done, held until next
module stack_op_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] imm,
  output logic [1:0]       stk_op,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_tos,
  input  logic [2:0]       stk_status,
  output logic             done,
  output logic [1:0]       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_OP,
    S_CHECK,
    S_BIN_CHECK,
    S_BIN_ISSUE
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PUSH = 3'd1,
    CMD_DROP = 3'd2,
    CMD_DUP  = 3'd3,
    CMD_EQZ  = 3'd4,
    CMD_ADD  = 3'd5,
    CMD_SUB  = 3'd6,
    CMD_AND  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_NONE      = 3'd0,
    ST_EMPTY     = 3'd1,
    ST_FULL      = 3'd2,
    ST_OVERFLOW  = 3'd3,
    ST_UNDERFLOW = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2
  } err_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  err_e             err_q, err_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             stk_empty;
  cmd_e             cmd_in;

  assign cmd_in    = cmd_e'(cmd);
  assign stk_empty = (stk_status == ST_EMPTY) || (stk_status == ST_UNDERFLOW);

  assign cmd_ready = (state_q == S_IDLE);
  assign stk_op    = op_q;
  assign stk_data  = data_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    op_d    = OP_NONE;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cmd_d   = cmd_q;
    b_d     = b_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // stk_op is NONE while idle, so stk_tos here is the settled top (b).
          cmd_d = cmd_in;
          b_d   = stk_tos;
          case (cmd_in)
            CMD_NOP: begin
              done_d = 1'b1;
              err_d  = ERR_OK;
            end
            CMD_PUSH: begin
              op_d    = OP_PUSH;
              data_d  = imm;
              state_d = S_ISSUE_OP;
            end
            CMD_DROP: begin
              op_d    = OP_POP;
              state_d = S_ISSUE_OP;
            end
            CMD_DUP: begin
              if (stk_empty) begin
                done_d = 1'b1;
                err_d  = ERR_UNDERFLOW;
              end else begin
                op_d    = OP_PUSH;
                data_d  = stk_tos;
                state_d = S_ISSUE_OP;
              end
            end
            CMD_EQZ: begin
              op_d    = OP_REPLACE;
              data_d  = (stk_tos == '0) ? WIDTH'(1) : '0;
              state_d = S_ISSUE_OP;
            end
            default: begin
              // Binary ops: pop b first, then replace a with the result.
              op_d    = OP_POP;
              state_d = S_ISSUE_OP;
            end
          endcase
        end
      end

      S_ISSUE_OP: begin
        state_d = (cmd_q == CMD_ADD || cmd_q == CMD_SUB || cmd_q == CMD_AND)
                  ? S_BIN_CHECK : S_CHECK;
      end

      S_CHECK: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (stk_status == ST_OVERFLOW) begin
          err_d = ERR_OVERFLOW;
        end else if (stk_status == ST_UNDERFLOW) begin
          err_d = ERR_UNDERFLOW;
        end else begin
          err_d = ERR_OK;
        end
      end

      S_BIN_CHECK: begin
        // EMPTY here means b was popped but there is no a; b stays consumed.
        if (stk_empty) begin
          done_d  = 1'b1;
          err_d   = ERR_UNDERFLOW;
          state_d = S_IDLE;
        end else begin
          op_d    = OP_REPLACE;
          state_d = S_BIN_ISSUE;
          case (cmd_q)
            CMD_ADD: data_d = stk_tos + b_q;
            CMD_SUB: data_d = stk_tos - b_q;
            default: data_d = stk_tos & b_q;
          endcase
        end
      end

      S_BIN_ISSUE: begin
        state_d = S_CHECK;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
      cmd_q   <= CMD_NOP;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Command-side master for the SuperStack operand stack.
- Accepts WebAssembly-style stack commands over a valid/ready handshake and drives SuperStack's op/data port as a multi-cycle sequence.
- Interprets SuperStack's status response and reports completion or error per command.
- Sits between the instruction decoder and one SuperStack instance; it is the only driver of that stack's op/data.

Parameters:
WIDTH, 8, data width; must match the attached SuperStack WIDTH.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; transfer occurs when cmd_valid and cmd_ready are both high at a rising edge.
cmd  in  3  0=NOP, 1=PUSH, 2=DROP, 3=DUP, 4=EQZ, 5=ADD, 6=SUB, 7=AND.
imm  in  WIDTH  immediate value for PUSH; sampled at transfer.
stk_op  out  2  to SuperStack op; stack.vh encodings NONE/PUSH/POP/REPLACE; registered.
stk_data  out  WIDTH  to SuperStack data; registered.
stk_tos  in  WIDTH  from SuperStack tos.
stk_status  in  3  from SuperStack status; stack.vh encodings NONE/EMPTY/FULL/OVERFLOW/UNDERFLOW.
done  out  1  one-cycle pulse at command completion.
err  out  2  0=ok, 1=underflow, 2=overflow. Valid with done; held until the next done.

Behaviour:
- Reset: state=IDLE, cmd_ready=1, stk_op=NONE, stk_data=0, done=0, err=0. Reset does not touch the stack contents. Reset mid-sequence abandons the sequence; a partially applied binary op leaves the stack one element shorter.
- States: IDLE, ISSUE_OP, CHECK, BIN_CHECK, BIN_ISSUE.
- stk_op is NONE in every cycle except the single cycle following an ISSUE transition.
- "Empty" means stk_status is EMPTY or UNDERFLOW.
- Transfer at edge E0 latches cmd, imm, and b=stk_tos. stk_tos is stable because stk_op is NONE in IDLE.
- NOP: done=1, err=0 after E0; no stack op.
- PUSH: stk_op=PUSH, stk_data=imm after E0. Stack executes at E1; FSM moves to CHECK. At E2, sample stk_status: OVERFLOW gives err=2, otherwise err=0; done=1 after E2; return to IDLE.
- DROP: same timing as PUSH with stk_op=POP. UNDERFLOW gives err=1.
- DUP: if empty at E0, done=1 and err=1 after E0 with no stack op. Otherwise PUSH of b, same timing as PUSH; OVERFLOW gives err=2.
- EQZ: stk_op=REPLACE, stk_data=(b==0)?1:0. UNDERFLOW gives err=1. Same timing as PUSH.
- ADD/SUB/AND: these are binary ops.
  - After E0, stk_op=POP.
  - At E1, move to BIN_CHECK.
  - At E2: if stk_status is UNDERFLOW or EMPTY, err=1 and done=1 after E2. In the EMPTY case operand b was consumed; this is documented as not restored.
  - Otherwise, after E2 drive stk_op=REPLACE, stk_data = a op b, where a=stk_tos sampled at E2. SUB computes a-b.
  - Arithmetic is modulo 2^WIDTH; no carry or overflow flag.
  - At E3, move to CHECK. At E4, sample status: UNDERFLOW gives err=1. done=1 after E4.
- Latency from transfer edge to done rising: NOP and empty-DUP 1 edge; unary 2 edges; binary 4 edges.
- cmd_ready=0 from transfer until the edge at which done rises. cmd_ready=1 again in the done cycle, so back-to-back commands are permitted.
- cmd_valid while not ready is ignored. cmd and imm need not be held after transfer.
- FULL after PUSH is not an error (err=0).
- stk_status is ignored except in the check cycles.

Test Plan (SuperStack WIDTH=8, DEPTH=1, capacity 2, underflow_limit=0):
- Reset low mid-ADD (after POP issued) -> immediately IDLE, stk_op=NONE, done=0, err=0. After release, stack holds one element.
- PUSH 3, PUSH 4, ADD -> done after 2, 2, 4 edges, err=0; tos=8'h07, status NONE. Then SUB with one element -> err=1, status EMPTY.
- PUSH 5, PUSH 9, PUSH 1 -> third done with err=2; tos=8'h09, status OVERFLOW.
- On empty stack: DROP -> err=1; DUP -> done one edge after transfer, err=1, stk_op stays NONE.
- PUSH 0, EQZ -> tos=8'h01. EQZ again -> tos=8'h00.
- PUSH 2, PUSH 5, SUB -> tos=8'hFD (wrap). PUSH 8'hF0, AND -> tos=8'hF0.
- Back-to-back PUSH 1, PUSH 2 with cmd_valid held high -> second transfer in the cycle done is high for the first; no idle gap.
